dec_ex_pipe: RTL and testbench



---
 rtl/dec_ex_pkg.sv | 12 +
 rtl/dec_ex_fwd_sel.sv | 36 +++
 rtl/dec_ex_pipe.sv | 165 ++++++++++++++++
 tb/tb_dec_ex_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dec_ex_pkg.sv
// Shared types and constants for the decode->execute pipeline register stage.
package dec_ex_pkg;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_e;

  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_e;

  localparam int X0           = 0;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 3;

endpackage

// File: rtl/dec_ex_fwd_sel.sv
// Operand forwarding mux: mem beats wb beats the supplied register value; x0 reads as 0.
module dec_ex_fwd_sel
  import dec_ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_rf_we,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_rf_we,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_NONE;
    if (mem_rf_we && mem_rd == addr)     sel = FWD_MEM;
    else if (wb_rf_we && wb_rd == addr)  sel = FWD_WB;
  end

  always_comb begin
    case (sel)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_data;
      default: fwd_data = data;
    endcase
    if (addr == RA_W'(X0)) fwd_data = '0;
  end

endmodule

// File: rtl/dec_ex_pipe.sv
// Registered decode->execute boundary with forwarding, load-use bubbling and flush.
// Define DEC_EX_PERF_CNT_EN to add saturating stall/bubble performance counters.
module dec_ex_pipe
  import dec_ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CTRL_W   = 24,
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [XLEN-1:0]   dec_pc_plus_4,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic [RA_W-1:0]   dec_rs1_addr,
  input  logic [RA_W-1:0]   dec_rs2_addr,
  input  logic [XLEN-1:0]   dec_rs1_data,
  input  logic [XLEN-1:0]   dec_rs2_data,
  input  logic [RA_W-1:0]   dec_rd,
  input  logic              dec_rf_we,
  input  logic              dec_is_load,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc_plus_4,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_opa,
  output logic [XLEN-1:0]   ex_opb,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_rf_we,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              mem_rf_we,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic              wb_rf_we,
  input  logic [XLEN-1:0]   wb_data,
  output logic              hazard_stall
`ifdef DEC_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_lat
    $error("dec_ex_pipe: LOAD_LAT out of range");
  end

  state_e          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic [RA_W-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] opa_q, opb_q, cap_rs1, cap_rs2;
  logic            lu_hit, in_xfer, out_xfer;

  assign lu_hit = ex_valid && ex_is_load && ex_rf_we && (ex_rd != RA_W'(X0)) && dec_valid &&
                  (dec_rs1_addr == ex_rd || dec_rs2_addr == ex_rd);
  assign dec_ready    = !flush && state == RUN && !lu_hit && (!ex_valid || ex_ready);
  assign in_xfer      = dec_valid && dec_ready;
  assign out_xfer     = ex_valid && ex_ready;
  assign hazard_stall = (state == BUBBLE);

  // Capture-side pre-forwarding, then live forwarding on the held operands.
  dec_ex_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_cap_rs1 (
    .addr(dec_rs1_addr), .data(dec_rs1_data), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data),
    .fwd_data(cap_rs1));
  dec_ex_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_cap_rs2 (
    .addr(dec_rs2_addr), .data(dec_rs2_data), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data),
    .fwd_data(cap_rs2));
  dec_ex_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_ex_opa (
    .addr(rs1_q), .data(opa_q), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data),
    .fwd_data(ex_opa));
  dec_ex_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W)) u_ex_opb (
    .addr(rs2_q), .data(opb_q), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data),
    .fwd_data(ex_opb));

  // BUBBLE lasts LOAD_LAT cycles: counter starts at LOAD_LAT-1 and exits at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: if (lu_hit && ex_ready) begin
        state_nxt = BUBBLE;
        cnt_nxt   = 2'(LOAD_LAT - 1);
      end
      BUBBLE: if (cnt == 2'd0) state_nxt = RUN;
              else             cnt_nxt   = cnt - 2'd1;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (flush) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_pc_plus_4 <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_rf_we     <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_ctrl      <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (in_xfer) begin
      ex_valid     <= 1'b1;
      ex_pc        <= dec_pc;
      ex_pc_plus_4 <= dec_pc_plus_4;
      ex_imm       <= dec_imm;
      ex_rd        <= dec_rd;
      ex_rf_we     <= dec_rf_we;
      ex_is_load   <= dec_is_load;
      ex_ctrl      <= dec_ctrl;
      rs1_q        <= dec_rs1_addr;
      rs2_q        <= dec_rs2_addr;
      opa_q        <= cap_rs1;
      opb_q        <= cap_rs2;
    end else if (out_xfer) begin
      ex_valid <= 1'b0;
    end else if (ex_valid) begin
      // A retiring writer must be latched now; it will not be visible on wb later.
      if (wb_rf_we && wb_rd == rs1_q && rs1_q != RA_W'(X0)) opa_q <= wb_data;
      if (wb_rf_we && wb_rd == rs2_q && rs2_q != RA_W'(X0)) opb_q <= wb_data;
    end
  end

`ifdef DEC_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (dec_valid && !dec_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (state == BUBBLE && perf_bubble_cnt != '1)        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dec_ex_pipe.sv
// Scoreboard bench for dec_ex_pipe (LOAD_LAT=2): forwarding, load-use bubble, hold refresh, flush.
module tb_dec_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, dec_valid, dec_ready, dec_rf_we, dec_is_load, ex_ready, ex_valid;
  logic [31:0] dec_pc, dec_pc_plus_4, dec_imm, dec_rs1_data, dec_rs2_data;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd, ex_rd, mem_rd, wb_rd;
  logic [23:0] dec_ctrl, ex_ctrl;
  logic [31:0] ex_pc, ex_pc_plus_4, ex_imm, ex_opa, ex_opb, mem_result, wb_data;
  logic        ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we, hazard_stall;
`ifdef DEC_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  dec_ex_pipe #(.XLEN(32), .CTRL_W(24), .RA_W(5), .LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_pc_plus_4(dec_pc_plus_4), .dec_imm(dec_imm),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_rd(dec_rd),
    .dec_rf_we(dec_rf_we), .dec_is_load(dec_is_load), .dec_ctrl(dec_ctrl),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus_4(ex_pc_plus_4),
    .ex_imm(ex_imm), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_data(wb_data),
    .hazard_stall(hazard_stall)
`ifdef DEC_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] opa;
    logic [31:0] opb;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] opa, input logic [31:0] opb);
    exp_t e;
    e.pc = pc; e.opa = opa; e.opb = opb;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; dec_valid = 0; dec_pc = '0; dec_pc_plus_4 = '0; dec_imm = '0;
    dec_rs1_addr = '0; dec_rs2_addr = '0; dec_rs1_data = '0; dec_rs2_data = '0;
    dec_rd = '0; dec_rf_we = 0; dec_is_load = 0; dec_ctrl = '0; ex_ready = 1;
    mem_rd = '0; mem_rf_we = 0; mem_result = '0; wb_rd = '0; wb_rf_we = 0; wb_data = '0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2,
                       input logic [4:0] rd, input logic ld);
    dec_valid = 1; dec_pc = pc; dec_pc_plus_4 = pc + 32'd4; dec_imm = pc ^ 32'h5A5A;
    dec_rs1_addr = rs1; dec_rs1_data = d1; dec_rs2_addr = rs2; dec_rs2_data = d2;
    dec_rd = rd; dec_rf_we = (rd != 0); dec_is_load = ld; dec_ctrl = pc[23:0];
  endtask

  // Output side: every out-transfer retires the oldest expected instruction.
  always @(negedge clk) begin
    if (rst && ex_valid && ex_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", ex_pc, e.pc);
        chk("out_opa", ex_opa, e.opa);
        chk("out_opb", ex_opb, e.opb);
      end
    end
  end

  initial begin
    rst = 0; idle();
    #2;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_opa", ex_opa, 0);
    tick(); rst = 1;
    #2 chk("rst_dec_ready", dec_ready, 1);

    // basic capture, then reset while held
    tick(); idle(); ex_ready = 0; drive(32'h100, 5'd1, 32'd5, 5'd0, 32'd0, 5'd0, 0);
    tick(); idle(); ex_ready = 0;
    #2;
    chk("cap_valid", ex_valid, 1);
    chk("cap_pc", ex_pc, 32'h100);
    chk("cap_opa", ex_opa, 32'd5);
    rst = 0;
    #1;
    chk("rst_mid_valid", ex_valid, 0);
    chk("rst_mid_pc", ex_pc, 0);
    rst = 1;

    // forwarding priority and hold refresh
    tick(); idle(); ex_ready = 0; drive(32'h200, 5'd3, 32'h11, 5'd0, 32'd0, 5'd0, 0);
    tick(); idle(); ex_ready = 0;
    mem_rd = 5'd3; mem_rf_we = 1; mem_result = 32'hAA; wb_rd = 5'd3; wb_rf_we = 1; wb_data = 32'hBB;
    #2 chk("fwd_mem", ex_opa, 32'hAA);
    tick(); mem_rf_we = 0;
    #2 chk("fwd_wb", ex_opa, 32'hBB);
    tick(); wb_rf_we = 0;
    #2 chk("hold_refresh_a", ex_opa, 32'hBB);
    // simultaneous out and in transfer; next instruction reads x0 while mem targets x0
    tick(); idle(); push(32'h200, 32'hBB, 32'h0);
    drive(32'h204, 5'd0, 32'h77, 5'd2, 32'h22, 5'd0, 0); push(32'h204, 32'h0, 32'h22);
    mem_rd = 5'd0; mem_rf_we = 1; mem_result = 32'hCC;
    #2 chk("simul_ready", dec_ready, 1);
    tick(); dec_valid = 0;
    #2;
    chk("simul_valid", ex_valid, 1);
    chk("x0_opa", ex_opa, 32'h0);
    tick(); idle();
    #2 chk("drain_valid", ex_valid, 0);

    // load-use hazard, LOAD_LAT=2
    drive(32'h300, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 1); push(32'h300, 32'h0, 32'h0);
    tick(); idle(); drive(32'h304, 5'd1, 32'd1, 5'd7, 32'd9, 5'd8, 0);
    #2;
    chk("lu_ready", dec_ready, 0);
    chk("lu_hazard", hazard_stall, 0);
    tick();
    #2;
    chk("b1_ready", dec_ready, 0);
    chk("b1_hazard", hazard_stall, 1);
    chk("b1_valid", ex_valid, 0);
    tick();
    #2;
    chk("b2_ready", dec_ready, 0);
    chk("b2_hazard", hazard_stall, 1);
    chk("b2_valid", ex_valid, 0);
    tick(); wb_rd = 5'd7; wb_rf_we = 1; wb_data = 32'h99; push(32'h304, 32'd1, 32'h99);
    #2;
    chk("run_ready", dec_ready, 1);
    chk("run_hazard", hazard_stall, 0);
    tick(); idle();
    #2;
    chk("cons_valid", ex_valid, 1);
    chk("cons_opb", ex_opb, 32'h99);
`ifdef DEC_EX_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, 32'd3);
    chk("perf_bubble", perf_bubble_cnt, 32'd2);
`endif

    // long downstream stall with wb refresh of stored rs2
    tick(); idle(); drive(32'h400, 5'd0, 32'd0, 5'd4, 32'h44, 5'd0, 0); push(32'h400, 32'h0, 32'h55);
    for (int i = 0; i < 5; i++) begin
      tick(); idle(); ex_ready = 0; drive(32'h404, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 0);
      if (i == 1) begin wb_rd = 5'd4; wb_rf_we = 1; wb_data = 32'h55; end
      #2;
      chk("hold_ready", dec_ready, 0);
      chk("hold_pc", ex_pc, 32'h400);
    end
    tick(); idle();
    #2 chk("rel_opb", ex_opb, 32'h55);

    // flush during bubble
    tick(); idle(); drive(32'h500, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 1); push(32'h500, 32'h0, 32'h0);
    tick(); idle(); drive(32'h504, 5'd5, 32'd3, 5'd0, 32'd0, 5'd6, 0);
    tick(); flush = 1;
    #2;
    chk("fl_hazard", hazard_stall, 1);
    chk("fl_ready", dec_ready, 0);
    tick(); flush = 0; dec_valid = 0;
    #2;
    chk("post_fl_valid", ex_valid, 0);
    chk("post_fl_hazard", hazard_stall, 0);
    chk("post_fl_ready", dec_ready, 1);
    tick();
    #2 chk("fl_nocap", ex_valid, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
